// File: rtl/lsu.sv
// RV32 load/store unit: takes one execute-stage request, runs it on a word-addressed
// valid/ready memory port, and returns formatted load data or a misalignment error.
module lsu (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reqValid,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                is_store_q, is_store_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic                resp_q, resp_d;

  logic                misaligned_c;
  logic [XLEN-1:0]     store_data_c;
  logic [STRB_W-1:0]   store_strb_c;
  logic [XLEN-1:0]     load_shift_c;
  logic [XLEN-1:0]     load_data_c;

  // Alignment check and store lane replication on the incoming request.
  always_comb begin
    misaligned_c = 1'b1;
    store_data_c = lsu_wdata;
    store_strb_c = '0;
    case (size)
      2'd0: begin
        misaligned_c = 1'b0;
        store_data_c = {4{lsu_wdata[7:0]}};
        store_strb_c = 4'b0001 << lsu_addr[1:0];
      end
      2'd1: begin
        misaligned_c = lsu_addr[0];
        store_data_c = {2{lsu_wdata[15:0]}};
        store_strb_c = 4'b0011 << lsu_addr[1:0];
      end
      2'd2: begin
        misaligned_c = |lsu_addr[1:0];
        store_strb_c = 4'b1111;
      end
      default: ;
    endcase
    if (!is_store) store_strb_c = '0;
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    load_shift_c = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_data_c = unsigned_q ? {24'b0, load_shift_c[7:0]}
                                        : {{24{load_shift_c[7]}}, load_shift_c[7:0]};
      2'd1:    load_data_c = unsigned_q ? {16'b0, load_shift_c[15:0]}
                                        : {{16{load_shift_c[15]}}, load_shift_c[15:0]};
      default: load_data_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          is_store_d = is_store;
          size_d     = size;
          unsigned_d = is_unsigned;
          addr_d     = lsu_addr;
          wdata_d    = store_data_c;
          wstrb_d    = store_strb_c;
          rdata_d    = '0;
          err_d      = misaligned_c;
          state_d    = misaligned_c ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (!is_store_q) rdata_d = load_data_c;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bus request and response pulse are registered copies of the next state.
    req_d  = (state_d == REQ);
    resp_d = (state_d == RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      req_q      <= req_d;
      resp_q     <= resp_d;
    end
  end

  assign respValid = resp_q;
  assign lsu_rdata = rdata_q;
  assign lsu_err   = err_q;
  assign mem_req   = req_q;
  assign mem_wen   = is_store_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit answering the execute stage's memory requests in the multi-cycle RISC-V core. It accepts one load or store per request pulse, drives a word-addressed valid/ready data-memory port, and returns load data to the execute stage with a one-cycle `respValid`. It formats RV32 byte, halfword and word accesses and rejects misaligned accesses locally.

## Interface
- No parameters. Data and address widths are fixed at 32 bits, matching `REG_W_END` = 31.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  one-cycle request pulse from execute; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load; sampled with `reqValid`.
- `size`  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- `is_unsigned`  in  1  zero-extend loads (LBU/LHU); ignored for stores.
- `lsu_addr`  in  32  byte address.
- `lsu_wdata`  in  32  store data; the low bytes are used for byte/half.
- `respValid`  out  1  one-cycle completion pulse.
- `lsu_rdata`  out  32  formatted load data; valid while `respValid` = 1.
- `lsu_err`  out  1  misaligned/illegal access; valid while `respValid` = 1.
- `mem_req`  out  1  bus request; held until `mem_ready`.
- `mem_wen`  out  1  write request.
- `mem_addr`  out  32  word address: {addr[31:2], 2'b00}.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte enables; 0 for loads.
- `mem_ready`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data / write acknowledge.
- `mem_rdata`  in  32  raw word from memory.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, `reqValid` = 1:
  - Latch `is_store`, `size`, `is_unsigned`, `lsu_addr`, `lsu_wdata`.
  - Misaligned means: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size = 3.
  - Misaligned: go to RESP with error flag set; no bus activity.
  - Otherwise: go to REQ.
- IDLE, `reqValid` = 0: stay in IDLE.
- REQ: `mem_req` = 1; `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wstrb` stable from latched values. `mem_ready` → WAIT; otherwise stay in REQ.
- WAIT: `mem_rvalid` → capture and format `mem_rdata` into the response register, then RESP. `mem_rvalid` is ignored in every other state.
- RESP: `respValid` = 1 for exactly one cycle, then IDLE. `lsu_rdata` is 0 for stores and errors; `lsu_err` = 0 except for rejected accesses.
- `reqValid` is ignored outside IDLE, including in RESP; requests are never queued.
- Store lane rules, with o = addr[1:0]:
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001 << o.
  - half: wdata = {2{wdata[15:0]}}, wstrb = 4'b0011 << o.
  - word: wdata unchanged, wstrb = 4'b1111.
- Load rules: s = mem_rdata >> (8·o).
  - byte: sign- or zero-extend s[7:0].
  - half: sign- or zero-extend s[15:0].
  - word: mem_rdata unchanged.

## Timing
- Reset (`reset_n` = 0, asynchronous): state = IDLE.
- Reset values: `respValid`, `mem_req`, `mem_wen`, `lsu_err` = 0; `lsu_rdata`, `mem_addr`, `mem_wdata`, `mem_wstrb`, and all latched fields = 0.
- Reset mid-transaction aborts immediately; `mem_req` drops asynchronously. No response is produced for the aborted request.
- Aligned access with zero wait states: `reqValid` at cycle 0 → `mem_req` at cycle 1 (`mem_ready` = 1) → `mem_rvalid` at cycle 2 → `respValid` at cycle 3. Minimum latency is 3 cycles.
- Each extra cycle of `mem_ready` = 0 or `mem_rvalid` = 0 adds one cycle.
- Misaligned access: `reqValid` at cycle 0 → `respValid` with `lsu_err` = 1 at cycle 1.
- `mem_req` is never deasserted before `mem_ready` = 1. It is deasserted the cycle after acceptance.
- Every output is registered or decoded from registered state only; there is no combinational path from `mem_*` inputs to outputs.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP, when the FSM is back in IDLE.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with zero wait states -> `mem_addr` = 0x100, `mem_wstrb` = 0; `respValid` 3 cycles after `reqValid`; `lsu_rdata` = 0xDEADBEEF; `lsu_err` = 0.
- LB then LBU at 0x103, word 0x80FF7F01 -> `lsu_rdata` = 0xFFFFFF80 for LB, then 0x00000080 for LBU; `mem_addr` = 0x100 for both.
- SH 0x1234ABCD at 0x202 -> `mem_wen` = 1, `mem_addr` = 0x200, `mem_wdata` = 0xABCDABCD, `mem_wstrb` = 4'b1100; `lsu_rdata` = 0 at `respValid`.
- LW at 0x101 -> `respValid` and `lsu_err` = 1 one cycle after the request; `mem_req` never rises.
- SW with `mem_ready` low 4 cycles and `mem_rvalid` delayed 2 more -> `mem_req` and its fields stay stable throughout the stall. `reqValid` pulses during the stall are ignored, and `respValid` arrives at cycle 9.
- `reset_n` pulled low while in WAIT -> `mem_req`/state clear immediately. A later `mem_rvalid` is ignored, no `respValid` pulse occurs, and a fresh LW completes normally.
